serial_3zero_tx: RTL and testbench

Serial frame transmitter for the three-zero-delimited bitstream that `detect_3zero` consumes. It accepts a parallel WIDTH-bit word through a load/ready handshake and shifts it out MSB-first on a single line. It terminates every frame with a `000` delimiter. When stuffing is compiled in, it inserts `1` bits so the payload can never contain three consecutive zeros, which makes the downstream detector fire only on the delimiter.

---
 rtl/serial_3zero_tx_pkg.sv | 15 +
 rtl/serial_3zero_tx.sv | 165 ++++++++++++++++
 tb/tb_serial_3zero_tx.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_3zero_tx_pkg.sv
// Shared types and constants for the three-zero-delimited serial transmitter.
package serial_3zero_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STUFF,
    DELIM
  } state_t;

  localparam int   DELIM_LEN    = 3;
  localparam logic IDLE_LEVEL   = 1'b1;
  localparam int   MAX_ZERO_RUN = 2;

endpackage

// File: rtl/serial_3zero_tx.sv
// MSB-first serial frame transmitter ending each frame with a 000 delimiter.
// Define ZERO_STUFF_EN to insert 1 bits so the payload never holds three zeros.
module serial_3zero_tx
  import serial_3zero_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             bitout,
  output logic             frame_done,
  output state_t           fsm_state
);

  localparam int              IDX_W      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WIDTH - 1);
  localparam logic [1:0]      LAST_DELIM = 2'(DELIM_LEN - 1);
  localparam logic [1:0]      PRE_LAST   = 2'(DELIM_LEN - 2);

  // Handshake: a word is taken on any edge where load=1 and the transmitter is
  // free (idle, or on its final delimiter bit); data must be stable at that edge.
  state_t             state_q, state_d;
  logic [WIDTH-2:0]   shreg_q, shreg_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         dcnt_q, dcnt_d;
  logic               bit_q, bit_d;
  logic               fd_q, fd_d;
  logic               start_frame;
`ifdef ZERO_STUFF_EN
  localparam logic [1:0] RUN_LIMIT = 2'(MAX_ZERO_RUN);
  logic [1:0]         zrun_q, zrun_d;
`endif

  assign start_frame = load && ((state_q == IDLE) ||
                                ((state_q == DELIM) && (dcnt_q == LAST_DELIM)));

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    dcnt_d  = dcnt_q;
    bit_d   = bit_q;
    fd_d    = 1'b0;
    case (state_q)
      IDLE: bit_d = IDLE_LEVEL;
      DATA: begin
`ifdef ZERO_STUFF_EN
        if (zrun_q == RUN_LIMIT) begin
          state_d = STUFF;
          bit_d   = 1'b1;
        end else if (idx_q == LAST_IDX) begin
          // A trailing payload zero gets a guard 1 so the delimiter run stays at three.
          if (zrun_q != 2'd0) begin
            state_d = STUFF;
            bit_d   = 1'b1;
          end else begin
            state_d = DELIM;
            dcnt_d  = 2'd0;
            bit_d   = 1'b0;
          end
        end else begin
          state_d = DATA;
          idx_d   = idx_q + 1'b1;
          shreg_d = shreg_q << 1;
          bit_d   = shreg_q[WIDTH-2];
        end
`else
        if (idx_q == LAST_IDX) begin
          state_d = DELIM;
          dcnt_d  = 2'd0;
          bit_d   = 1'b0;
        end else begin
          state_d = DATA;
          idx_d   = idx_q + 1'b1;
          shreg_d = shreg_q << 1;
          bit_d   = shreg_q[WIDTH-2];
        end
`endif
      end
`ifdef ZERO_STUFF_EN
      STUFF: begin
        if (idx_q == LAST_IDX) begin
          state_d = DELIM;
          dcnt_d  = 2'd0;
          bit_d   = 1'b0;
        end else begin
          state_d = DATA;
          idx_d   = idx_q + 1'b1;
          shreg_d = shreg_q << 1;
          bit_d   = shreg_q[WIDTH-2];
        end
      end
`endif
      DELIM: begin
        if (dcnt_q == LAST_DELIM) begin
          state_d = IDLE;
          bit_d   = IDLE_LEVEL;
        end else begin
          dcnt_d = dcnt_q + 2'd1;
          bit_d  = 1'b0;
          fd_d   = (dcnt_q == PRE_LAST);
        end
      end
      default: begin
        state_d = IDLE;
        bit_d   = IDLE_LEVEL;
      end
    endcase
    if (start_frame) begin
      state_d = DATA;
      shreg_d = data[WIDTH-2:0];
      idx_d   = '0;
      bit_d   = data[WIDTH-1];
    end
  end

`ifdef ZERO_STUFF_EN
  // The zero run restarts with every frame so stuffing is frame-local.
  always_comb begin
    zrun_d = zrun_q;
    if (start_frame) begin
      zrun_d = data[WIDTH-1] ? 2'd0 : 2'd1;
    end else if (bit_d) begin
      zrun_d = 2'd0;
    end else if (zrun_q != 2'd3) begin
      zrun_d = zrun_q + 2'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      zrun_q <= 2'd0;
    end else begin
      zrun_q <= zrun_d;
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      dcnt_q  <= 2'd0;
      bit_q   <= IDLE_LEVEL;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      dcnt_q  <= dcnt_d;
      bit_q   <= bit_d;
      fd_q    <= fd_d;
    end
  end

  assign ready      = (state_q == IDLE);
  assign bitout     = bit_q;
  assign frame_done = fd_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_serial_3zero_tx.sv
// Bench for serial_3zero_tx: line-level frame model, per-cycle compare, directed frames.
module tb_serial_3zero_tx;
  import serial_3zero_tx_pkg::*;

  localparam int W = 8;
`ifdef ZERO_STUFF_EN
  localparam bit STUFF_ON = 1'b1;
  localparam int L_00 = 15;
  localparam int L_B2 = 13;
  localparam int L_3C = 13;
  localparam logic [63:0] LIT_00 = 64'b001001001001000;
  localparam logic [63:0] LIT_B2 = 64'b1011001101000;
  localparam logic [63:0] LIT_3C = 64'b0011111001000;
`else
  localparam bit STUFF_ON = 1'b0;
  localparam int L_00 = 11;
  localparam int L_B2 = 11;
  localparam int L_3C = 11;
  localparam logic [63:0] LIT_00 = 64'b00000000000;
  localparam logic [63:0] LIT_B2 = 64'b10110010000;
  localparam logic [63:0] LIT_3C = 64'b00111100000;
`endif
  localparam int L_FF = 11;
  localparam logic [63:0] LIT_FF = 64'b11111111000;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic load  = 1'b0;
  logic [W-1:0] data = '0;
  logic   ready, bitout, frame_done;
  state_t fsm_state;

  always #5 clock = ~clock;

  serial_3zero_tx #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .load(load),
    .data(data),
    .ready(ready),
    .bitout(bitout),
    .frame_done(frame_done),
    .fsm_state(fsm_state)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Frame bits MSB-first in the low n bits of the result (first bit is highest).
  function automatic int build_frame(input logic [W-1:0] d, output logic [63:0] bits);
    int n;
    int run;
    n = 0;
    run = 0;
    bits = '0;
    for (int i = W - 1; i >= 0; i--) begin
      bits = {bits[62:0], d[i]};
      n++;
      run = d[i] ? 0 : run + 1;
      if (STUFF_ON && run == MAX_ZERO_RUN) begin
        bits = {bits[62:0], 1'b1};
        n++;
        run = 0;
      end
    end
    if (STUFF_ON && run != 0) begin
      bits = {bits[62:0], 1'b1};
      n++;
    end
    for (int k = 0; k < DELIM_LEN; k++) begin
      bits = {bits[62:0], 1'b0};
      n++;
    end
    return n;
  endfunction

  // scoreboard: queue of line bits still to appear for the current frame
  logic [0:0]  exp_q[$];
  logic        m_bit    = 1'b1;
  logic        m_ready  = 1'b1;
  logic        m_fd     = 1'b0;
  logic        m_active = 1'b0;
  logic        m_accept;
  logic [63:0] m_bits;
  int          m_len;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      m_bit    = 1'b1;
      m_ready  = 1'b1;
      m_fd     = 1'b0;
      m_active = 1'b0;
    end else begin
      m_accept = m_ready || (m_active && exp_q.size() == 0);
      if (load && m_accept) begin
        m_len = build_frame(data, m_bits);
        for (int i = m_len - 1; i >= 0; i--) exp_q.push_back(m_bits[i]);
        m_bit    = exp_q.pop_front();
        m_ready  = 1'b0;
        m_active = 1'b1;
        m_fd     = 1'b0;
      end else if (exp_q.size() != 0) begin
        m_bit = exp_q.pop_front();
        m_fd  = (exp_q.size() == 0);
      end else begin
        m_bit    = 1'b1;
        m_ready  = 1'b1;
        m_active = 1'b0;
        m_fd     = 1'b0;
      end
    end
  end

  // per-cycle compare plus a loopback three-zero detector
  int   det_run = 0;
  logic det;

  always @(negedge clock) begin
    check1("bitout", bitout, m_bit);
    check1("ready", ready, m_ready);
    check1("frame_done", frame_done, m_fd);
    det = 1'b0;
    if (reset || bitout) begin
      det_run = 0;
    end else begin
      det_run++;
      if (det_run == 3) begin
        det = 1'b1;
        det_run = 0;
      end
    end
`ifdef ZERO_STUFF_EN
    check1("loopback_det", det, frame_done);
`endif
  end

  // driver tasks
  task automatic send_and_capture(input logic [W-1:0] d, input int n,
                                  output logic [63:0] bits, output logic [63:0] fds);
    @(posedge clock);
    #2 load = 1'b1;
    data = d;
    @(posedge clock);
    #2 load = 1'b0;
    bits = '0;
    fds  = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      bits = {bits[62:0], bitout};
      fds  = {fds[62:0], frame_done};
    end
  endtask

  task automatic frame_test(input string name, input logic [W-1:0] d, input int n,
                            input logic [63:0] lit);
    logic [63:0] bits, fds;
    send_and_capture(d, n, bits, fds);
    check({name, "_bits"}, bits, lit);
    check({name, "_done"}, fds, 64'd1);
    @(negedge clock);
    check1({name, "_ready_after"}, ready, 1'b1);
    check1({name, "_idle_after"}, bitout, 1'b1);
  endtask

  initial begin
    logic [63:0] bits, fds, pin_bits;
    int          pin_len, fd_seen;

    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check1("reset_bitout", bitout, 1'b1);
    check1("reset_ready", ready, 1'b1);
    check1("reset_frame_done", frame_done, 1'b0);
    check("reset_state", 64'(fsm_state), 64'(IDLE));
    #2 reset = 1'b0;

    // pin the model against hand-derived frames
    pin_len = build_frame(8'hB2, pin_bits);
    check("model_len_B2", 64'(pin_len), 64'(L_B2));
    check("model_bits_B2", pin_bits, LIT_B2);
    pin_len = build_frame(8'h00, pin_bits);
    check("model_len_00", 64'(pin_len), 64'(L_00));
    check("model_bits_00", pin_bits, LIT_00);

    frame_test("ff", 8'hFF, L_FF, LIT_FF);
    frame_test("zero", 8'h00, L_00, LIT_00);
    frame_test("b2", 8'hB2, L_B2, LIT_B2);

    // busy load ignored, then a held load accepted with no gap after the delimiter
    @(posedge clock);
    #2 load = 1'b1;
    data = 8'hFF;
    @(posedge clock);
    #2 load = 1'b0;
    bits = '0;
    fds  = '0;
    for (int k = 1; k <= L_FF + L_3C; k++) begin
      @(negedge clock);
      bits = {bits[62:0], bitout};
      fds  = {fds[62:0], frame_done};
      if (k == 3) begin
        load = 1'b1;
        data = 8'hA5;
      end
      if (k == 4) load = 1'b0;
      if (k == 10) begin
        load = 1'b1;
        data = 8'h3C;
      end
      if (k == 12) load = 1'b0;
    end
    check("b2b_bits", bits, (LIT_FF << L_3C) | LIT_3C);
    check("b2b_done", fds, (64'd1 << L_3C) | 64'd1);
    @(negedge clock);
    check1("b2b_ready_after", ready, 1'b1);

    // reset during the 4th payload bit of F0
    @(posedge clock);
    #2 load = 1'b1;
    data = 8'hF0;
    @(posedge clock);
    #2 load = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check1("abort_bitout", bitout, 1'b1);
    check1("abort_ready", ready, 1'b1);
    @(posedge clock);
    @(negedge clock);
    #1 reset = 1'b0;
    fd_seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      if (frame_done) fd_seen++;
    end
    check("abort_no_done", 64'(fd_seen), 64'd0);
    frame_test("ff_after_abort", 8'hFF, L_FF, LIT_FF);

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
